// File: rtl/memshare_regfile_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : memshare_regfile_loader_pkg
//  Purpose  : Shared state encoding and L1PA type-0 register-file defaults
//             for the memShare register-file loader.
//  Revision : 1.0 - initial release
// ============================================================================
package memshare_regfile_loader_pkg;

  // Register-file geometry defaults for the L1PA type-0 pages.
  localparam int L1PA_REGFILE_ADDR_WIDTH = 6;
  localparam int L1PA_REGFILE_PAGE_WIDTH = 7;
  localparam int L1PA_REGFILE_PAGE_NUM   = 64;

  // Loader control states; encodings are fixed so other blocks can decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loaderState_t;

endpackage : memshare_regfile_loader_pkg
`default_nettype wire

// File: rtl/memshare_regfile_loader_addrgen.sv
`default_nettype none
// ============================================================================
//  Module   : memShare_loader_addrGen
//  Purpose  : Loadable modulo-PAGE_NUM page-address counter with a remaining
//             page down-counter and a last-beat flag.
//  Revision : 1.0 - initial release
// ============================================================================
module memShare_loader_addrGen #(
  parameter int ADDR_W   = 6,
  parameter int PAGE_NUM = 64,
  parameter int LEN_W    = 7
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_step,
  output logic [ADDR_W-1:0] o_curAddr,
  output logic [LEN_W-1:0]  o_remain,
  output logic              o_lastBeat
);

  localparam logic [ADDR_W-1:0] c_lastAddr = ADDR_W'(PAGE_NUM - 1);
  localparam logic [LEN_W-1:0]  c_oneLen   = LEN_W'(1);

  logic [ADDR_W-1:0] r_curAddr;
  logic [LEN_W-1:0]  r_remain;
  logic [ADDR_W-1:0] w_nextAddr;

  // A page count that fills the whole address space wraps for free; any
  // other page count needs an explicit compare against the last page.
  generate
    if (PAGE_NUM == (1 << ADDR_W)) begin : g_naturalWrap
      assign w_nextAddr = r_curAddr + 1'b1;
    end else begin : g_explicitWrap
      assign w_nextAddr = (r_curAddr == c_lastAddr) ? '0 : r_curAddr + 1'b1;
    end
  endgenerate

  // Load takes priority; each accepted beat advances the address and
  // consumes one page of the remaining count.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_curAddr <= '0;
      r_remain  <= '0;
    end else if (i_load) begin
      r_curAddr <= i_base;
      r_remain  <= i_len;
    end else if (i_step) begin
      r_curAddr <= w_nextAddr;
      r_remain  <= r_remain - 1'b1;
    end
  end

  assign o_curAddr  = r_curAddr;
  assign o_remain   = r_remain;
  assign o_lastBeat = (r_remain == c_oneLen);

endmodule : memShare_loader_addrGen
`default_nettype wire

// File: rtl/memshare_regfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : memshare_regfile_loader
//  Purpose  : Accepts a (base, length) load command and a stream of page
//             words, writing them to consecutive type-0 register-file pages
//             with wrap-around. Flags completion and illegal commands.
//  Revision : 1.0 - initial release
// ============================================================================
module memshare_regfile_loader
  import memshare_regfile_loader_pkg::*;
#(
  parameter int TYPE0_ADDR_BITWIDTH = L1PA_REGFILE_ADDR_WIDTH,
  parameter int TYPE0_REG_BITWIDTH  = L1PA_REGFILE_PAGE_WIDTH,
  parameter int TYPE0_PAGE_NUM      = L1PA_REGFILE_PAGE_NUM,
  parameter int LEN_BITWIDTH        = $clog2(TYPE0_PAGE_NUM) + 1
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [TYPE0_ADDR_BITWIDTH-1:0] cmd_base_i,
  input  logic [LEN_BITWIDTH-1:0]        cmd_len_i,
  input  logic                           data_valid_i,
  output logic                           data_ready_o,
  input  logic [TYPE0_REG_BITWIDTH-1:0]  data_i,
  input  logic                           abort_i,
  output logic [TYPE0_ADDR_BITWIDTH-1:0] regType0_waddr_o,
  output logic [TYPE0_REG_BITWIDTH-1:0]  regType0_wdata_o,
  output logic                           regType0_we_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam logic [LEN_BITWIDTH-1:0] c_pageNumLen = LEN_BITWIDTH'(TYPE0_PAGE_NUM);

  loaderState_t r_state;
  loaderState_t w_nextState;

  logic w_cmdReadyRaw;
  logic w_dataReadyRaw;
  logic w_cmdFire;
  logic w_dataFire;
  logic w_cmdLegal;

  logic [TYPE0_ADDR_BITWIDTH-1:0] w_curAddr;
  logic [LEN_BITWIDTH-1:0]        w_remain;
  logic                           w_lastBeat;

  logic [TYPE0_ADDR_BITWIDTH-1:0] r_waddr;
  logic [TYPE0_REG_BITWIDTH-1:0]  r_wdata;
  logic                           r_we;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_err;

  // Handshake readiness is held low while reset is asserted so nothing is
  // accepted in a cycle whose effects reset is about to discard.
  assign cmd_ready_o  = w_cmdReadyRaw  & ~rst;
  assign data_ready_o = w_dataReadyRaw & ~rst;
  assign w_cmdFire    = cmd_valid_i  & cmd_ready_o;
  assign w_dataFire   = data_valid_i & data_ready_o;
  assign w_cmdLegal   = (cmd_len_i != '0) && (cmd_len_i <= c_pageNumLen);

  memShare_loader_addrGen #(
    .ADDR_W   (TYPE0_ADDR_BITWIDTH),
    .PAGE_NUM (TYPE0_PAGE_NUM),
    .LEN_W    (LEN_BITWIDTH)
  ) u_addrGen (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .i_load     (w_cmdFire),
    .i_base     (cmd_base_i),
    .i_len      (cmd_len_i),
    .i_step     (w_dataFire),
    .o_curAddr  (w_curAddr),
    .o_remain   (w_remain),
    .o_lastBeat (w_lastBeat)
  );

  // State register.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and handshake-readiness decode.
  always_comb begin
    w_nextState    = r_state;
    w_cmdReadyRaw  = 1'b0;
    w_dataReadyRaw = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cmdReadyRaw = 1'b1;
        if (cmd_valid_i && w_cmdLegal) begin
          w_nextState = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_dataReadyRaw = ~abort_i;
        if (abort_i) begin
          w_nextState = ST_IDLE;
        end else if (data_valid_i && w_lastBeat) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Registered write port and status pulses; the write lands one cycle after
  // its data handshake, and the address/data hold between writes.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= w_dataFire;
      r_done <= w_dataFire & w_lastBeat;
      r_err  <= w_cmdFire & ~w_cmdLegal;
      r_busy <= (w_nextState != ST_IDLE);
      if (w_dataFire) begin
        r_waddr <= w_curAddr;
        r_wdata <= data_i;
      end
    end
  end

  assign regType0_we_o    = r_we;
  assign regType0_waddr_o = r_waddr;
  assign regType0_wdata_o = r_wdata;
  assign busy_o           = r_busy;
  assign done_o           = r_done;
  assign err_o            = r_err;

endmodule : memshare_regfile_loader
`default_nettype wire

// File: tb/tb_memshare_regfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memshare_regfile_loader
//  Purpose  : Self-checking bench for memshare_regfile_loader: directed
//             scenarios followed by random traffic against a queue-based
//             transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memshare_regfile_loader;

  localparam int c_pageNum = 64;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       cmd_valid_i;
  logic       cmd_ready_o;
  logic [5:0] cmd_base_i;
  logic [6:0] cmd_len_i;
  logic       data_valid_i;
  logic       data_ready_o;
  logic [6:0] data_i;
  logic       abort_i;
  logic [5:0] regType0_waddr_o;
  logic [6:0] regType0_wdata_o;
  logic       regType0_we_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 = idle, 1 = loading, 2 = completion cycle.
  int ph = 0;
  int addrQ[$];
  int eAddr = 0;
  int eData = 0;

  always #5 sys_clk = ~sys_clk;

  memshare_regfile_loader dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .cmd_valid_i      (cmd_valid_i),
    .cmd_ready_o      (cmd_ready_o),
    .cmd_base_i       (cmd_base_i),
    .cmd_len_i        (cmd_len_i),
    .data_valid_i     (data_valid_i),
    .data_ready_o     (data_ready_o),
    .data_i           (data_i),
    .abort_i          (abort_i),
    .regType0_waddr_o (regType0_waddr_o),
    .regType0_wdata_o (regType0_wdata_o),
    .regType0_we_o    (regType0_we_o),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check readiness, predict, clock, check outputs.
  task automatic cycle(input bit iRst, input bit iCmdV, input int iBase, input int iLen,
                       input bit iDV, input int iData, input bit iAbort);
    bit eWe, eDone, eErr, eBusy, chkWr;
    rst          = iRst;
    cmd_valid_i  = iCmdV;
    cmd_base_i   = iBase[5:0];
    cmd_len_i    = iLen[6:0];
    data_valid_i = iDV;
    data_i       = iData[6:0];
    abort_i      = iAbort;
    #1;
    chk("cmd_ready",  cmd_ready_o,  (!iRst && ph == 0) ? 1 : 0);
    chk("data_ready", data_ready_o, (!iRst && ph == 1 && !iAbort) ? 1 : 0);
    eWe = 0; eDone = 0; eErr = 0; chkWr = 0;
    if (iRst) begin
      ph = 0;
      addrQ.delete();
      eAddr = 0;
      eData = 0;
      chkWr = 1;
    end else begin
      case (ph)
        0: if (iCmdV) begin
          if (iLen < 1 || iLen > c_pageNum) begin
            eErr = 1;
          end else begin
            for (int i = 0; i < iLen; i++) addrQ.push_back((iBase + i) % c_pageNum);
            ph = 1;
          end
        end
        1: if (iAbort) begin
          ph = 0;
          addrQ.delete();
        end else if (iDV) begin
          eWe   = 1;
          eAddr = addrQ.pop_front();
          eData = iData;
          chkWr = 1;
          if (addrQ.size() == 0) begin
            ph    = 2;
            eDone = 1;
          end
        end
        default: ph = 0;
      endcase
    end
    eBusy = (ph != 0);
    @(posedge sys_clk);
    #1;
    chk("we",   regType0_we_o, eWe);
    chk("done", done_o,        eDone);
    chk("err",  err_o,         eErr);
    chk("busy", busy_o,        eBusy);
    if (chkWr) begin
      chk("waddr", regType0_waddr_o, eAddr);
      chk("wdata", regType0_wdata_o, eData);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmd(input int base, input int len);
    cycle(0, 1, base, len, 0, 0, 0);
  endtask

  task automatic beat(input int d);
    cycle(0, 0, 0, 0, 1, d, 0);
  endtask

  initial begin
    // Reset for two cycles, then a quiet cycle.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    idle(1);

    // Base 5, three back-to-back beats.
    cmd(5, 3);
    beat('h11); beat('h22); beat('h33);
    idle(2);

    // Address wrap from the top page.
    cmd(62, 4);
    for (int i = 0; i < 4; i++) beat(i + 1);
    idle(2);

    // Illegal lengths, with stray data/abort in idle ignored.
    cmd(3, 0);
    cycle(0, 0, 0, 0, 1, 'h55, 1);
    cmd(3, 65);
    idle(2);

    // Abort after two beats while the third is valid.
    cmd(10, 5);
    beat('h01); beat('h02);
    cycle(0, 0, 0, 0, 1, 'h03, 1);
    idle(2);

    // Reset mid-load, then a fresh command.
    cmd(20, 4);
    beat('h0a); beat('h0b);
    cycle(1, 0, 0, 0, 1, 'h0c, 0);
    cmd(3, 1);
    beat('h7f);
    idle(2);

    // Valid every third cycle.
    cmd(40, 8);
    for (int i = 0; i < 24; i++) cycle(0, 0, 0, 0, (i % 3) == 2, 'h40 + i, 0);
    idle(2);

    // Full-length load from a nonzero base, with a stray command held valid.
    cmd(7, c_pageNum);
    for (int i = 0; i < c_pageNum; i++) cycle(0, 1, 9, 2, 1, i, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99, 0) == 0,
            $urandom_range(3, 0) == 0,
            int'($urandom_range(63, 0)),
            ($urandom_range(9, 0) == 0) ? int'($urandom_range(70, 0)) : int'($urandom_range(12, 1)),
            $urandom_range(1, 0) == 1,
            int'($urandom_range(127, 0)),
            $urandom_range(24, 0) == 0);
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_memshare_regfile_loader
`default_nettype wire

// File: doc/memshare_regfile_loader.md
# memShare_regFile_loader

Upstream configuration stage for the memShare L1PA type-0 register file. Accepts a load command (base page, page count) and a stream of page words over valid/ready handshakes. Writes the words into consecutive register-file pages through the type-0 write port (`regType0_waddr/wdata/we`), with address wrap-around. Reports completion and illegal commands to the host so L1PA shift sequences can be (re)programmed between decoding runs.

## Interface
- `TYPE0_ADDR_BITWIDTH`, default 6: page address width.
- `TYPE0_REG_BITWIDTH`, default 7: page word width.
- `TYPE0_PAGE_NUM`, default 64: number of pages; legal addresses are 0..TYPE0_PAGE_NUM-1.
- `LEN_BITWIDTH`, default `$clog2(TYPE0_PAGE_NUM)+1`: page-count width.

Clock and reset: one clock; reset is synchronous and active-high.
- `sys_clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous active-high reset.

Command and data ports:
- `cmd_valid_i`  in  1  load command valid.
- `cmd_ready_o`  out  1  loader can accept a command.
- `cmd_base_i`  in  TYPE0_ADDR_BITWIDTH  first page to write.
- `cmd_len_i`  in  LEN_BITWIDTH  number of pages; legal range is 1..TYPE0_PAGE_NUM.
- `data_valid_i`  in  1  page word valid.
- `data_ready_o`  out  1  loader accepts a page word.
- `data_i`  in  TYPE0_REG_BITWIDTH  page word.
- `abort_i`  in  1  cancel the current load.

Register-file and status ports:
- `regType0_waddr_o`  out  TYPE0_ADDR_BITWIDTH  register-file write address.
- `regType0_wdata_o`  out  TYPE0_REG_BITWIDTH  register-file write data.
- `regType0_we_o`  out  1  register-file write enable.
- `busy_o`  out  1  a load is in progress.
- `done_o`  out  1  one-cycle pulse: last page written.
- `err_o`  out  1  one-cycle pulse: illegal command rejected.

## Operation
States are IDLE, LOAD and DONE.

- **IDLE**
  - `cmd_ready_o`=1 and `data_ready_o`=0.
  - A command handshake latches `cmd_base_i` into `cur_addr` and `cmd_len_i` into `remain`.
  - If `cmd_len_i`==0 or `cmd_len_i`>TYPE0_PAGE_NUM: `err_o` pulses the next cycle, no write occurs, and the state stays IDLE.
  - Otherwise the state moves to LOAD.
- **LOAD**
  - `cmd_ready_o`=0; `data_ready_o`=~`abort_i`; `busy_o`=1.
  - Each data handshake registers a write: the next cycle has `regType0_we_o`=1, `waddr`=`cur_addr`, `wdata`=`data_i`.
  - `cur_addr` increments modulo TYPE0_PAGE_NUM (TYPE0_PAGE_NUM-1 → 0); `remain` decrements.
  - The handshake with `remain`==1 is the last beat; the state moves to DONE.
- **DONE**
  - Lasts one cycle; the write for the last beat is issued in this cycle.
  - `done_o`=1, `busy_o`=1, `cmd_ready_o`=0, `data_ready_o`=0.
  - The state then returns to IDLE.
- **Abort**
  - `abort_i`=1 in LOAD: no beat is accepted that cycle and the state moves to IDLE.
  - Writes already registered still complete; `done_o` does not pulse and `err_o` does not pulse.
  - `abort_i` in IDLE or DONE is ignored.
- **Ignored inputs**
  - `data_valid_i` in IDLE or DONE is ignored; the word stays pending at the source.
  - `cmd_valid_i` outside IDLE is not accepted.
- **Width rules**
  - Address arithmetic is TYPE0_ADDR_BITWIDTH wide with an explicit wrap when TYPE0_PAGE_NUM is not a power of two.
  - The `remain` comparison is LEN_BITWIDTH wide.

## Timing
- Reset values: state=IDLE; `cmd_ready_o`=0 during reset and 1 from the first cycle after reset; `data_ready_o`=0, `regType0_we_o`=0, `waddr`=0, `wdata`=0, `busy_o`=0, `done_o`=0, `err_o`=0.
- Command handshake to first `data_ready_o`=1: 1 cycle.
- Data handshake to write: 1 cycle. Back-to-back beats give one write per cycle (full throughput).
- Last handshake at cycle N: last write and `done_o` at N+1; `cmd_ready_o`=1 at N+2.
- Illegal command accepted at N: `err_o` at N+1; `cmd_ready_o` stays 1.
- A length equal to TYPE0_PAGE_NUM with a nonzero base wraps and overwrites every page exactly once.
- Reset asserted mid-load: the state returns to IDLE the next cycle, the pending write is dropped (`we`=0) and no `done_o` is produced.
- All outputs are registered, except `cmd_ready_o` and `data_ready_o`, which are decoded from state and `abort_i`.

## Structure
- Shared package / `memShare_config.vh`: state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2) and the `L1PA_REGFILE_ADDR_WIDTH`, `L1PA_REGFILE_PAGE_WIDTH` and `L1PA_REGFILE_PAGE_NUM` defaults.
- Sub-module `memShare_loader_addrGen`: a loadable modulo-TYPE0_PAGE_NUM address counter with a `remain` down-counter and a last-beat flag.
- The FSM and write register stay in the top of this block.

## Test plan
- Base=5, len=3, data 0x11,0x22,0x33 back-to-back: writes (5,0x11),(6,0x22),(7,0x33) on consecutive cycles; `done_o` coincides with the (7,0x33) write.
- Base=62, len=4 with TYPE0_PAGE_NUM=64: write addresses 62,63,0,1; `done_o` once.
- len=0, then len=65: `err_o` pulses 1 cycle after each; no `we`; `cmd_ready_o` stays 1.
- Base=10, len=5, `abort_i` after 2 beats with the third beat valid: writes only to 10 and 11; no `done_o`; IDLE the next cycle.
- Reset asserted the cycle after the second beat of a len=4 load: no write on the reset cycle; all outputs at reset values; a new command is accepted after reset.
- Random gaps on `data_valid_i` (e.g. valid every third cycle), len=8: exactly 8 writes, ascending addresses, each 1 cycle after its handshake.
